timestamp_unit: RTL and testbench

//  Parametrised successor to the fixed 32-bit free-running timestamp counter.
//  - Adds a runtime prescaler, count enable, loadable sync value and an epoch (rollover) counter.
//  - Adds NUM_CH event-capture channels. Each latches {epoch,timestamp} on an event rising edge.
//  - Captures are held for the event builder under a valid/ready handshake.

---
 rtl/timestamp_pkg.sv | 16 +
 rtl/timestamp_unit_if.sv | 30 +++
 rtl/timestamp_capture_ch.sv | 57 +++++
 rtl/timestamp_unit.sv | 91 +++++++++
 tb/tb_timestamp_unit.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/timestamp_pkg.sv
// Shared constants and types for the timestamp unit: default widths and the
// per-cycle counter operation selected by the priority resolver.
package timestamp_pkg;

   localparam int TS_W_DEF    = 32;
   localparam int EPOCH_W_DEF = 16;
   localparam int NUM_CH_DEF  = 4;
   localparam int PRE_W_DEF   = 8;

   typedef enum logic [1:0] {
      CNT_HOLD = 2'd0,
      CNT_TICK = 2'd1,
      CNT_SYNC = 2'd2
   } cnt_op_e;

endpackage

// File: rtl/timestamp_unit_if.sv
// Event-capture bus between the timestamp unit (master) and the event builder
// (slave): per-channel event inputs, capture data, valid/ready and lost flags.
interface timestamp_unit_if #(
   parameter int NUM_CH  = 4,
   parameter int TS_W    = 32,
   parameter int EPOCH_W = 16
);

   // Handshake: a capture transfers in any cycle where cap_valid[i] & cap_ready[i];
   // cap_ts/cap_epoch are stable while cap_valid[i]=1 and cap_ready[i]=0, and
   // cap_valid[i] drops the cycle after a transfer unless a new edge reloads it.
   logic [NUM_CH-1:0]               event_in;
   logic [NUM_CH-1:0][TS_W-1:0]     cap_ts;
   logic [NUM_CH-1:0][EPOCH_W-1:0]  cap_epoch;
   logic [NUM_CH-1:0]               cap_valid;
   logic [NUM_CH-1:0]               cap_ready;
   logic [NUM_CH-1:0]               cap_lost;
   logic [NUM_CH-1:0]               lost_clr;

   modport master (
      input  event_in, cap_ready, lost_clr,
      output cap_ts, cap_epoch, cap_valid, cap_lost
   );

   modport slave (
      output event_in, cap_ready, lost_clr,
      input  cap_ts, cap_epoch, cap_valid, cap_lost
   );

endinterface

// File: rtl/timestamp_capture_ch.sv
// One event-capture channel: rising-edge detector, snapshot registers,
// valid/ready hold logic and sticky lost flag.
module timestamp_capture_ch #(
   parameter int TS_W    = 32,
   parameter int EPOCH_W = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               event_in,
   input  logic [TS_W-1:0]    cur_ts,
   input  logic [EPOCH_W-1:0] cur_epoch,
   input  logic               cap_ready,
   input  logic               lost_clr,
   output logic [TS_W-1:0]    cap_ts,
   output logic [EPOCH_W-1:0] cap_epoch,
   output logic               cap_valid,
   output logic               cap_lost
);

   logic prev;
   logic edge_det;
   logic xfer;
   logic load;
   logic drop;

   assign edge_det = event_in & ~prev;
   assign xfer     = cap_valid & cap_ready;
   // A new edge may reuse the slot in the same cycle the old capture is taken.
   assign load     = edge_det & (~cap_valid | xfer);
   assign drop     = edge_det & cap_valid & ~xfer;

   // prev resets high so a level held through reset is not seen as an edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prev      <= 1'b1;
         cap_ts    <= '0;
         cap_epoch <= '0;
         cap_valid <= 1'b0;
         cap_lost  <= 1'b0;
      end else begin
         prev <= event_in;
         if (load) begin
            cap_ts    <= cur_ts;
            cap_epoch <= cur_epoch;
            cap_valid <= 1'b1;
         end else if (xfer) begin
            cap_valid <= 1'b0;
         end
         if (drop) begin
            cap_lost <= 1'b1;
         end else if (lost_clr) begin
            cap_lost <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/timestamp_unit.sv
// Free-running timestamp with runtime prescaler, sync load and epoch counter,
// plus NUM_CH event-capture channels snapshotting {epoch, timestamp}.
module timestamp_unit
   import timestamp_pkg::*;
#(
   parameter int TS_W    = TS_W_DEF,
   parameter int EPOCH_W = EPOCH_W_DEF,
   parameter int NUM_CH  = NUM_CH_DEF,
   parameter int PRE_W   = PRE_W_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               enable,
   input  logic               sync_timestamp,
   input  logic [TS_W-1:0]    sync_value,
   input  logic [PRE_W-1:0]   prescale,
   output logic [TS_W-1:0]    timestamp,
   output logic [EPOCH_W-1:0] epoch,
   output logic               rollover,
   timestamp_unit_if.master   cap
);

   logic [PRE_W-1:0] pcnt;
   logic             tick;
   cnt_op_e          op;

   // pcnt is compared against the live prescale, so lowering prescale below
   // pcnt lets it wrap through all-ones before the next tick.
   assign tick = enable && (pcnt == prescale);

   always_comb begin
      op = CNT_HOLD;
      if (sync_timestamp) begin
         op = CNT_SYNC;
      end else if (tick) begin
         op = CNT_TICK;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         timestamp <= '0;
         epoch     <= '0;
         pcnt      <= '0;
         rollover  <= 1'b0;
      end else begin
         case (op)
            CNT_SYNC: begin
               timestamp <= sync_value;
               epoch     <= '0;
               pcnt      <= '0;
               rollover  <= 1'b0;
            end
            CNT_TICK: begin
               timestamp <= timestamp + TS_W'(1);
               pcnt      <= '0;
               rollover  <= &timestamp;
               if (&timestamp) begin
                  epoch <= epoch + EPOCH_W'(1);
               end
            end
            default: begin
               if (enable) begin
                  pcnt <= pcnt + PRE_W'(1);
               end
               rollover <= 1'b0;
            end
         endcase
      end
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      timestamp_capture_ch #(
         .TS_W    (TS_W),
         .EPOCH_W (EPOCH_W)
      ) u_ch (
         .clk       (clk),
         .reset     (reset),
         .event_in  (cap.event_in[i]),
         .cur_ts    (timestamp),
         .cur_epoch (epoch),
         .cap_ready (cap.cap_ready[i]),
         .lost_clr  (cap.lost_clr[i]),
         .cap_ts    (cap.cap_ts[i]),
         .cap_epoch (cap.cap_epoch[i]),
         .cap_valid (cap.cap_valid[i]),
         .cap_lost  (cap.cap_lost[i])
      );
   end

endmodule

// File: tb/tb_timestamp_unit.sv
// Directed bench for timestamp_unit: a counter vector table plus hand-written
// capture, handshake and reset sequences.
module tb_timestamp_unit;

   localparam int TS_W    = 32;
   localparam int EPOCH_W = 16;
   localparam int NUM_CH  = 4;
   localparam int PRE_W   = 8;

   typedef struct {
      logic              en;
      logic              sync;
      logic [TS_W-1:0]   sval;
      logic [PRE_W-1:0]  pre;
      logic [TS_W-1:0]   exp_ts;
      logic [EPOCH_W-1:0] exp_ep;
      logic              exp_ro;
   } vec_t;

   logic               clk;
   logic               reset;
   logic               enable;
   logic               sync_timestamp;
   logic [TS_W-1:0]    sync_value;
   logic [PRE_W-1:0]   prescale;
   logic [TS_W-1:0]    timestamp;
   logic [EPOCH_W-1:0] epoch;
   logic               rollover;

   int n_total;
   int n_pass;

   timestamp_unit_if #(.NUM_CH(NUM_CH), .TS_W(TS_W), .EPOCH_W(EPOCH_W)) cap_if ();

   timestamp_unit #(
      .TS_W    (TS_W),
      .EPOCH_W (EPOCH_W),
      .NUM_CH  (NUM_CH),
      .PRE_W   (PRE_W)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .enable         (enable),
      .sync_timestamp (sync_timestamp),
      .sync_value     (sync_value),
      .prescale       (prescale),
      .timestamp      (timestamp),
      .epoch          (epoch),
      .rollover       (rollover),
      .cap            (cap_if.master)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input int n = 1);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      enable         = 1'b0;
      sync_timestamp = 1'b0;
      cap_if.cap_ready = '0;
      cap_if.lost_clr  = '0;
      reset = 1'b1;
      #1;
      chk("rst_ts", 64'(timestamp), 64'd0);
      chk("rst_epoch", 64'(epoch), 64'd0);
      chk("rst_rollover", 64'(rollover), 64'd0);
      chk("rst_valid", 64'(cap_if.cap_valid), 64'd0);
      chk("rst_lost", 64'(cap_if.cap_lost), 64'd0);
      chk("rst_cap_ts1", 64'(cap_if.cap_ts[1]), 64'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   vec_t vecs[14];

   initial begin
      n_total = 0;
      n_pass  = 0;
      reset = 1'b1;
      enable = 1'b0;
      sync_timestamp = 1'b0;
      sync_value = '0;
      prescale = '0;
      cap_if.event_in  = '0;
      cap_if.cap_ready = '0;
      cap_if.lost_clr  = '0;

      // counting at prescale 0, then sync near wrap and rollover
      for (int i = 0; i < 10; i++)
         vecs[i] = '{1'b1, 1'b0, 32'd0, 8'd0, 32'(i + 1), 16'd0, 1'b0};
      vecs[10] = '{1'b1, 1'b1, 32'hFFFF_FFFE, 8'd0, 32'hFFFF_FFFE, 16'd0, 1'b0};
      vecs[11] = '{1'b1, 1'b0, 32'd0, 8'd0, 32'hFFFF_FFFF, 16'd0, 1'b0};
      vecs[12] = '{1'b1, 1'b0, 32'd0, 8'd0, 32'h0000_0000, 16'd1, 1'b1};
      vecs[13] = '{1'b1, 1'b0, 32'd0, 8'd0, 32'h0000_0001, 16'd1, 1'b0};

      do_reset();
      for (int i = 0; i < 14; i++) begin
         enable         = vecs[i].en;
         sync_timestamp = vecs[i].sync;
         sync_value     = vecs[i].sval;
         prescale       = vecs[i].pre;
         step();
         chk($sformatf("vec%0d_ts", i), 64'(timestamp), 64'(vecs[i].exp_ts));
         chk($sformatf("vec%0d_epoch", i), 64'(epoch), 64'(vecs[i].exp_ep));
         chk($sformatf("vec%0d_rollover", i), 64'(rollover), 64'(vecs[i].exp_ro));
      end
      sync_timestamp = 1'b0;

      // simultaneous edges on ch1 and ch3 capture the same {epoch, ts}
      cap_if.event_in = 4'b1010;
      step();
      chk("multi_valid", 64'(cap_if.cap_valid), 64'b1010);
      chk("multi_ts1", 64'(cap_if.cap_ts[1]), 64'd1);
      chk("multi_ts3", 64'(cap_if.cap_ts[3]), 64'd1);
      chk("multi_ep3", 64'(cap_if.cap_epoch[3]), 64'd1);
      cap_if.event_in  = '0;
      cap_if.cap_ready = 4'b1010;
      step();
      chk("multi_drain", 64'(cap_if.cap_valid), 64'd0);
      cap_if.cap_ready = '0;

      // prescale 3: 12 cycles -> 3 ticks, then hold while disabled
      do_reset();
      prescale = 8'd3;
      enable   = 1'b1;
      step(12);
      chk("pre3_ts", 64'(timestamp), 64'd3);
      enable = 1'b0;
      step(5);
      chk("hold_ts", 64'(timestamp), 64'd3);

      // lower prescale below pcnt: pcnt wraps through all-ones first
      enable = 1'b1;
      step(3);
      prescale = 8'd1;
      step(254);
      chk("pwrap_before", 64'(timestamp), 64'd3);
      step();
      chk("pwrap_tick", 64'(timestamp), 64'd4);

      // capture, drop, lost clear on ch2
      prescale = 8'd0;
      sync_value = 32'd95;
      sync_timestamp = 1'b1;
      step();
      sync_timestamp = 1'b0;
      chk("sync95", 64'(timestamp), 64'd95);
      step(5);
      cap_if.event_in = 4'b0100;
      step();
      chk("c2_valid", 64'(cap_if.cap_valid), 64'b0100);
      chk("c2_ts", 64'(cap_if.cap_ts[2]), 64'd100);
      chk("c2_ep", 64'(cap_if.cap_epoch[2]), 64'd0);
      cap_if.event_in = '0;
      step(9);
      chk("ts110", 64'(timestamp), 64'd110);
      cap_if.event_in = 4'b0100;
      step();
      chk("c2_lost", 64'(cap_if.cap_lost), 64'b0100);
      chk("c2_ts_kept", 64'(cap_if.cap_ts[2]), 64'd100);
      cap_if.event_in = '0;
      cap_if.lost_clr = 4'b0100;
      step();
      cap_if.lost_clr = '0;
      chk("c2_lost_clr", 64'(cap_if.cap_lost), 64'd0);
      cap_if.event_in = 4'b0100;
      cap_if.lost_clr = 4'b0100;
      step();
      cap_if.event_in = '0;
      cap_if.lost_clr = '0;
      chk("c2_set_wins", 64'(cap_if.cap_lost), 64'b0100);
      cap_if.cap_ready = 4'b0100;
      step();
      cap_if.cap_ready = '0;
      chk("c2_xfer", 64'(cap_if.cap_valid), 64'd0);
      chk("c2_lost_sticky", 64'(cap_if.cap_lost), 64'b0100);

      // edge coincident with transfer on ch0 reloads and stays valid
      sync_value = 32'd195;
      sync_timestamp = 1'b1;
      step();
      sync_timestamp = 1'b0;
      cap_if.event_in = 4'b0001;
      step();
      chk("c0_ts195", 64'(cap_if.cap_ts[0]), 64'd195);
      cap_if.event_in = '0;
      step(4);
      cap_if.event_in  = 4'b0001;
      cap_if.cap_ready = 4'b0001;
      step();
      cap_if.event_in  = '0;
      cap_if.cap_ready = '0;
      chk("c0_valid", 64'(cap_if.cap_valid[0]), 64'd1);
      chk("c0_ts200", 64'(cap_if.cap_ts[0]), 64'd200);
      chk("c0_nolost", 64'(cap_if.cap_lost[0]), 64'd0);

      // sync while a capture is pending leaves it untouched
      sync_value = 32'd5;
      sync_timestamp = 1'b1;
      step();
      sync_timestamp = 1'b0;
      chk("sync5_ts", 64'(timestamp), 64'd5);
      chk("sync_keep_ts", 64'(cap_if.cap_ts[0]), 64'd200);
      chk("sync_keep_valid", 64'(cap_if.cap_valid[0]), 64'd1);

      // level held high through reset is not an edge
      cap_if.event_in = 4'hF;
      do_reset();
      enable = 1'b1;
      step(3);
      chk("held_no_cap", 64'(cap_if.cap_valid), 64'd0);

      // asynchronous reset mid-count with a capture pending
      cap_if.event_in = '0;
      step(2);
      cap_if.event_in = 4'b0001;
      step();
      chk("pre_rst_valid", 64'(cap_if.cap_valid[0]), 64'd1);
      reset = 1'b1;
      #1;
      chk("arst_ts", 64'(timestamp), 64'd0);
      chk("arst_valid", 64'(cap_if.cap_valid), 64'd0);
      chk("arst_cap_ts0", 64'(cap_if.cap_ts[0]), 64'd0);
      chk("arst_lost", 64'(cap_if.cap_lost), 64'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
